div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
Multi-cycle radix-2 restoring divider sequencer for the EX stage, serving DIV/DIVU.
- EX asserts start_i with operands and holds it until ready_o; EX stalls the pipeline while start_i && !ready_o.
- Output is 64 bits: remainder in [63:32] for HI, quotient in [31:0] for LO.
- Annul lets the pipeline abort an in-flight division on flush.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  request; held high by EX until the result is consumed
- annul_i  input  1  abort current or pending division
- result_o  output  2*DATA_W  {remainder, quotient}; registered
- ready_o  output  1  result_o valid; registered

Behaviour:
- Reset: when rst is high at a clk edge: state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor/shift registers=0.
- States and transitions:
  - FREE:
    - start_i && !annul_i && opdata2_i==0 -> BY_ZERO.
    - start_i && !annul_i, divisor nonzero -> ON. Capture absolute values of both operands when signed_div_i, raw values otherwise. Capture signed_div_i and both sign bits. cnt=0; partial remainder=0.
    - Otherwise stay in FREE with ready_o=0 and result_o=0.
  - BY_ZERO: next edge -> END with result 0.
  - ON:
    - annul_i -> FREE; ready_o=0; result_o=0.
    - Else, while cnt<DATA_W: each edge shifts {rem,quo} left by 1 and trial-subtracts the divisor from rem. If there is no borrow, rem=difference and quo LSB=1; otherwise quo LSB=0. cnt++.
    - At cnt==DATA_W: apply sign correction, load result_o, set ready_o=1 -> END.
  - END:
    - ready_o=1; result_o held stable.
    - !start_i or annul_i -> FREE; result_o=0 and ready_o=0 on the same edge.
- Sign correction, signed mode only:
  - Quotient is negated when the captured dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0 (wraps; no exception).
- Latency, counting the first edge on which start_i is sampled high as edge 1:
  - Normal division: ready_o is high after edge 34 (1 accept + 32 steps + 1 correct).
  - Divide by zero: ready_o is high after edge 2.
- Operands are sampled only at accept. Changes to opdata*/signed_div_i during ON/BY_ZERO/END are ignored.
- Annul in BY_ZERO also returns to FREE. annul_i has priority over start_i in every state.
- No new request is accepted in the same edge that leaves END. Back-to-back divisions need start_i low for at least one cycle.
- rst asserted mid-operation: return to the reset state on the next edge. rst has priority over annul_i and start_i.

Optional Feature:
Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, on accept with nonzero divisor, if |dividend| < |divisor| (unsigned magnitudes), go directly to END with q=0 and r=original dividend (sign preserved). ready_o is high after edge 1.
- Undefined: all nonzero-divisor requests take the full 34-edge path. Results are identical either way; only latency differs.

Decomposition:
- Shared defines.v gets:
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop.
- The EX stage gets new aluop codes EXE_DIV_OP/EXE_DIVU_OP and the stallreq path.
- Sub-module: a combinational div_step (one trial subtraction: rem, quo, divisor in; next rem/quo out) is natural and unit-testable. It is optional; no other sub-modules.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0), start held -> ready_o rises after edge 34; result_o=0x00000002_0000000E.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- Divisor 0, any dividend -> ready_o high after edge 2; result_o=0. Dropping start_i returns ready_o to 0 on the next edge.
- Annul on edge 10 of a division -> ready_o stays 0, FREE re-entered. Drop start, then a fresh 20/5 -> q=4, r=0 after 34 edges. rst mid-ON -> ready_o=0, result_o=0 next edge.
- Hold start_i high 5 cycles in END while toggling opdata inputs -> result_o and ready_o unchanged. Deassert -> ready_o=0 next edge.
- DIV_EARLY_OUT_EN defined: 3 / 10 unsigned -> ready_o after edge 1, result_o=0x00000003_00000000. Macro undefined: same result after edge 34.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the div_seq radix-2 restoring divider.
// State encodings and handshake level names used by the sequencer.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and
// trial-subtract the divisor from the widened partial remainder.
module div_seq_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0]   rem_sh;
  logic [W-1:0] diff;
  logic         fits;

  // When the shifted remainder overflows W bits it always exceeds the
  // divisor, and the true difference still fits in W bits, so the
  // W-bit wrapped subtraction is exact in that case.
  always_comb begin
    rem_sh   = {rem, quo[W-1]};
    diff     = rem_sh[W-1:0] - divisor;
    fits     = rem_sh[W] | (rem_sh[W-1:0] >= divisor);
    rem_next = fits ? diff : rem_sh[W-1:0];
    quo_next = {quo[W-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o qualifies it.
// Optional build macro DIV_EARLY_OUT_EN: finish in one edge when
// |dividend| < |divisor| (q=0, r=dividend); results are unchanged.
//
// state   | meaning
// --------+----------------------------------------------------------
// FREE    | idle, waiting for start_i; outputs held at zero
// BY_ZERO | divisor was zero; one edge later report a zero result
// ON      | iterating, one quotient bit per edge, then sign-correct
// END     | result valid; held until start_i drops or annul_i
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e               state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [DATA_W-1:0]        rem, rem_n;
  logic [DATA_W-1:0]        quo, quo_n;
  logic [DATA_W-1:0]        dvs, dvs_n;
  logic                     sgn_mode, sgn_mode_n;
  logic                     sgn1, sgn1_n;
  logic                     sgn2, sgn2_n;
  logic [2*DATA_W-1:0]      result_n;
  logic                     ready_n;

  logic [DATA_W-1:0]        op1_mag, op2_mag;
  logic [DATA_W-1:0]        step_rem, step_quo;
  logic [DATA_W-1:0]        q_fix, r_fix;
  logic                     early_hit;
  logic                     go;

  div_seq_step #(.W(DATA_W)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes at accept, and sign correction of the final result.
  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    q_fix   = (sgn_mode && (sgn1 ^ sgn2)) ? -quo : quo;
    r_fix   = (sgn_mode && sgn1) ? -rem : rem;
    go      = (start_i == DIV_START) && !annul_i;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = op1_mag < op2_mag;
`else
  assign early_hit = 1'b0;
`endif

  // Next-state and datapath decode; every register holds by default.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    quo_n      = quo;
    dvs_n      = dvs;
    sgn_mode_n = sgn_mode;
    sgn1_n     = sgn1;
    sgn2_n     = sgn2;
    result_n   = result_o;
    ready_n    = ready_o;
    unique case (state)
      DIV_FREE: begin
        ready_n  = DIV_RESULT_NOT_READY;
        result_n = '0;
        if (go) begin
          if (opdata2_i == '0) begin
            state_n = DIV_BY_ZERO;
          end else if (early_hit) begin
            state_n  = DIV_END;
            result_n = {opdata1_i, {DATA_W{1'b0}}};
            ready_n  = DIV_RESULT_READY;
          end else begin
            state_n    = DIV_ON;
            cnt_n      = '0;
            rem_n      = '0;
            quo_n      = op1_mag;
            dvs_n      = op2_mag;
            sgn_mode_n = signed_div_i;
            sgn1_n     = opdata1_i[DATA_W-1];
            sgn2_n     = opdata2_i[DATA_W-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_n = DIV_FREE;
        end else begin
          state_n  = DIV_END;
          result_n = '0;
          ready_n  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_n  = DIV_FREE;
          ready_n  = DIV_RESULT_NOT_READY;
          result_n = '0;
        end else if (cnt != CNT_LAST) begin
          rem_n = step_rem;
          quo_n = step_quo;
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = DIV_END;
          result_n = {r_fix, q_fix};
          ready_n  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        ready_n = DIV_RESULT_READY;
        if ((start_i == DIV_STOP) || annul_i) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sgn_mode <= 1'b0;
      sgn1     <= 1'b0;
      sgn2     <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      sgn_mode <= sgn_mode_n;
      sgn1     <= sgn1_n;
      sgn2     <= sgn2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: expected results and latencies are
// queued when a request is driven and compared when ready_o rises.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? 32'd0 - a : a;
    mb = (sgn && b[31]) ? 32'd0 - b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 34;
  endfunction

  // Runs one full request: hold start until ready, optionally stay in END
  // for `hold` cycles while scrambling inputs, then drop start.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int hold);
    exp_t e;
    int   n;
    bit   seen;
    e.res = model_res(a, b, sgn);
    e.lat = model_lat(a, b, sgn);
    sb.push_back(e);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (ready_o === 1'b1) seen = 1;
    end
    e = sb.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: ready_o never rose within %0d edges, want %0d", name, n, e.lat);
    end else begin
      if (n !== e.lat) begin
        bad++;
        $display("FAIL %s latency: got %0d edges, want %0d", name, n, e.lat);
      end
      total++;
      if (result_o !== e.res) begin
        bad++;
        $display("FAIL %s result: got %h, want %h", name, result_o, e.res);
      end
    end
    for (int h = 0; h < hold; h++) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~signed_div_i;
      @(posedge clk); #1;
      total++;
      if (ready_o !== 1'b1 || result_o !== e.res) begin
        bad++;
        $display("FAIL %s hold%0d: got ready=%b res=%h, want ready=1 res=%h",
                 name, h, ready_o, result_o, e.res);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL %s release: got ready=%b res=%h, want ready=0 res=0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset: got ready=%b res=%h, want ready=0 res=0", ready_o, result_o);
    end
    start_i = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_idle: got ready=%b res=%h, want ready=0 res=0", ready_o, result_o);
    end
  endtask

  task automatic test_unsigned();
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 0);
    do_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_div("u3_10", 32'd3, 32'd10, 1'b0, 0);
    do_div("u0_5", 32'd0, 32'd5, 1'b0, 0);
    do_div("ubig", 32'hDEAD_BEEF, 32'h0001_2345, 1'b0, 0);
  endtask

  task automatic test_signed();
    do_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_div("s-8_-3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 0);
    do_div("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 0);
  endtask

  task automatic test_by_zero();
    do_div("z_u", 32'h1234, 32'd0, 1'b0, 0);
    do_div("z_s", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL z_annul: got ready=%b, want 0", ready_o);
    end
  endtask

  task automatic test_annul();
    bit leak;
    @(negedge clk);
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_edge: got ready=%b res=%h, want ready=0 res=0", ready_o, result_o);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    leak    = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) leak = 1;
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL annul_quiet: got ready pulse after annul, want none");
    end
    do_div("a20_5", 32'd20, 32'd5, 1'b0, 0);
  endtask

  task automatic test_rst_mid();
    bit leak;
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst     = 1'b1;
    annul_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    rst     = 1'b0;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL rst_on: got ready=%b res=%h, want ready=0 res=0", ready_o, result_o);
    end
    leak = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) leak = 1;
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL rst_quiet: got ready pulse after reset, want none");
    end
    @(negedge clk);
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL rst_end: got ready=%b res=%h, want ready=0 res=0", ready_o, result_o);
    end
    rst     = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold_end();
    do_div("hold100_7", 32'd100, 32'd7, 1'b0, 5);
    do_div("hold_s", 32'hFFFF_FF00, 32'd9, 1'b1, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 4 == 1) b = a + 32'd1;
      s = 1'($urandom_range(0, 1));
      do_div("b2b", a, b, s, 0);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_by_zero();
    test_annul();
    test_rst_mid();
    test_hold_end();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
